// File: rtl/meter_pkg.sv
// meter_pkg: segment patterns, digit positions and reader state shared by the
// seven-segment meter reader and its decoder.
package meter_pkg;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [1:0] DIG_ONES  = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_HUNDS = 2'd2;
  localparam logic [1:0] DIG_THOUS = 2'd3;
  localparam logic [13:0] MAX_COUNT = 14'd9999;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_BLANK} rd_state_e;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: active-low seven-segment pattern (g..a) back to a BCD digit.
module seg7_decode
  import meter_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] digit_o
);
  always_comb begin
    valid_o = 1'b1;
    digit_o = 4'd0;
    case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/meter_reader.sv
// meter_reader: passive monitor of the meter's multiplexed display bus; rebuilds
// four-digit frames and reports blanking, flashing and expiry.
module meter_reader
  import meter_pkg::*;
#(
  parameter int SETTLE        = 4,
  parameter int BLANK_TIMEOUT = 1_000_000,
  parameter int FLASH_HOLD    = 300_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] count_bcd,
  output logic [13:0] count_bin,
  output logic        frame_valid,
  output logic        decode_err,
  output logic        blank,
  output logic        flashing,
  output logic        expired
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int BW = $clog2(BLANK_TIMEOUT + 1);
  localparam int FW = $clog2(FLASH_HOLD + 1);
  localparam logic [BW-1:0] BT = BW'(BLANK_TIMEOUT);
  localparam logic [FW-1:0] FH = FW'(FLASH_HOLD);

  rd_state_e        state_q;
  logic [10:0]      s1_q, s2_q, last_q;
  logic [SW-1:0]    stab_q;
  logic [BW-1:0]    blk_q, blk_d;
  logic [FW-1:0]    flash_q;
  logic [3:0][3:0]  slot_q, slot_d;
  logic [3:0]       mask_q, mask_d;
  logic [15:0]      count_bcd_q;
  logic [13:0]      count_bin_q, bin_d;
  logic             frame_valid_q, decode_err_q, expired_q;
  logic [3:0]       an_s, dig;
  logic [1:0]       pos;
  logic             dec_valid, accept, cap, err, resume, sat, done;

  seg7_decode u_dec (.seg_i(s2_q[6:0]), .valid_o(dec_valid), .digit_o(dig));

  assign an_s   = s2_q[10:7];
  // The counter saturates at SETTLE, so a stable interval is accepted only once.
  assign accept = (s2_q == last_q) && (stab_q == SW'(SETTLE - 1));
  assign pos    = !an_s[DIG_ONES] ? DIG_ONES : !an_s[DIG_TENS] ? DIG_TENS :
                  !an_s[DIG_HUNDS] ? DIG_HUNDS : DIG_THOUS;
  assign cap    = accept && $onehot(~an_s) && dec_valid;
  assign err    = accept && (an_s != 4'hF) && !cap;
  assign resume = (state_q == ST_BLANK) && (an_s != 4'hF);
  assign blk_d  = (an_s != 4'hF) ? '0 : (blk_q == BT) ? blk_q : blk_q + 1'b1;
  assign sat    = blk_d == BT;
  assign done   = mask_d == 4'hF;
  assign bin_d  = 14'(slot_d[3]) * 14'd1000 + 14'(slot_d[2]) * 14'd100 +
                  14'(slot_d[1]) * 14'd10 + 14'(slot_d[0]);

  always_comb begin
    slot_d = slot_q;
    mask_d = resume ? 4'h0 : mask_q;
    if (cap) begin
      slot_d[pos] = dig;
      mask_d[pos] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      s1_q          <= '1;
      s2_q          <= '1;
      last_q        <= '1;
      stab_q        <= '0;
      blk_q         <= '0;
      flash_q       <= '0;
      slot_q        <= '0;
      mask_q        <= '0;
      count_bcd_q   <= '0;
      count_bin_q   <= '0;
      frame_valid_q <= 1'b0;
      decode_err_q  <= 1'b0;
      expired_q     <= 1'b0;
    end else begin
      s1_q          <= {an, seg};
      s2_q          <= s1_q;
      last_q        <= s2_q;
      stab_q        <= (s2_q != last_q) ? '0 : (stab_q == SW'(SETTLE)) ? stab_q : stab_q + 1'b1;
      blk_q         <= blk_d;
      flash_q       <= resume ? FH : (flash_q != '0) ? flash_q - 1'b1 : flash_q;
      slot_q        <= slot_d;
      mask_q        <= done ? 4'h0 : mask_d;
      frame_valid_q <= done;
      decode_err_q  <= err;
      if (done) begin
        count_bcd_q <= slot_d;
        count_bin_q <= (bin_d > MAX_COUNT) ? MAX_COUNT : bin_d;
        expired_q   <= bin_d == 14'd0;
      end
      case (state_q)
        ST_IDLE:  state_q <= sat ? ST_BLANK : cap ? ST_SCAN : ST_IDLE;
        ST_SCAN:  state_q <= sat ? ST_BLANK : ST_SCAN;
        ST_BLANK: state_q <= resume ? ST_SCAN : ST_BLANK;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign count_bcd   = count_bcd_q;
  assign count_bin   = count_bin_q;
  assign frame_valid = frame_valid_q;
  assign decode_err  = decode_err_q;
  assign blank       = state_q == ST_BLANK;
  assign flashing    = flash_q != '0;
  assign expired     = expired_q;
endmodule

// File: tb/tb_meter_reader.sv
// tb_meter_reader: randomized frames scanned onto the display bus and checked
// against digit-level arithmetic kept in the bench.
module tb_meter_reader;
  localparam int BT = 300;
  localparam int FH = 2000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] count_bcd;
  logic [13:0] count_bin;
  logic        frame_valid, decode_err, blank, flashing, expired;

  meter_reader #(.SETTLE(4), .BLANK_TIMEOUT(BT), .FLASH_HOLD(FH)) dut (
    .clk(clk), .reset_n(reset_n), .an(an), .seg(seg),
    .count_bcd(count_bcd), .count_bin(count_bin), .frame_valid(frame_valid),
    .decode_err(decode_err), .blank(blank), .flashing(flashing), .expired(expired)
  );

  always #5 clk = ~clk;

  logic [6:0] pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int n_cmp = 0, n_bad = 0;
  int fv_cnt = 0, err_cnt = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (decode_err) err_cnt++;
    if (frame_valid && decode_err) both_cnt++;
  end

  task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input int p, input int v, input int n);
    logic [3:0] one;
    one = 4'b0001;
    show(~(one << p), pats[v], n);
  endtask

  function automatic logic [15:0] to_bcd(input int d [4]);
    return {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
  endfunction

  function automatic int to_bin(input int d [4]);
    return d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
  endfunction

  task automatic test_reset;
    n_cmp++;
    if ({count_bcd, count_bin, frame_valid, decode_err, blank, flashing, expired} !== '0) begin
      n_bad++;
      $display("FAIL reset_in: outputs %h want 0", {count_bcd, count_bin, frame_valid, decode_err, blank, flashing, expired});
    end
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({count_bcd, count_bin, frame_valid, decode_err, blank, flashing, expired} !== '0 || fv_cnt + err_cnt != 0) begin
      n_bad++;
      $display("FAIL reset_out: outputs %h fv %0d err %0d want 0", {count_bcd, count_bin, blank, flashing, expired}, fv_cnt, err_cnt);
    end
  endtask

  task automatic test_frame_0206;
    int d [4] = '{6, 0, 2, 0};
    int f0 = fv_cnt;
    for (int p = 3; p >= 0; p--) put(p, d[p], 1000);
    show(4'hF, 7'h7F, 10);
    n_cmp++;
    if (fv_cnt - f0 != 1) begin n_bad++; $display("FAIL f0206_count: got %0d frames want 1", fv_cnt - f0); end
    n_cmp++;
    if (count_bcd !== 16'h0206) begin n_bad++; $display("FAIL f0206_bcd: got %h want 0206", count_bcd); end
    n_cmp++;
    if (count_bin !== 14'd206) begin n_bad++; $display("FAIL f0206_bin: got %0d want 206", count_bin); end
    n_cmp++;
    if (expired !== 1'b0) begin n_bad++; $display("FAIL f0206_expired: got %b want 0", expired); end
  endtask

  task automatic test_9999_0000;
    int f0 = fv_cnt;
    for (int p = 3; p >= 0; p--) put(p, 9, 40);
    show(4'hF, 7'h7F, 10);
    n_cmp++;
    if (count_bin !== 14'd9999 || count_bcd !== 16'h9999 || expired !== 1'b0) begin
      n_bad++;
      $display("FAIL f9999: got bcd %h bin %0d exp %b want 9999/9999/0", count_bcd, count_bin, expired);
    end
    for (int p = 3; p >= 0; p--) put(p, 0, 40);
    show(4'hF, 7'h7F, 10);
    n_cmp++;
    if (count_bin !== 14'd0 || count_bcd !== 16'h0000 || expired !== 1'b1) begin
      n_bad++;
      $display("FAIL f0000: got bcd %h bin %0d exp %b want 0000/0/1", count_bcd, count_bin, expired);
    end
    n_cmp++;
    if (fv_cnt - f0 != 2) begin n_bad++; $display("FAIL f9999_count: got %0d frames want 2", fv_cnt - f0); end
  endtask

  task automatic test_random_frames;
    int d [4];
    for (int i = 0; i < 8; i++) begin
      int f0 = fv_cnt;
      for (int p = 0; p < 4; p++) d[p] = $urandom_range(9);
      put(3, $urandom_range(9), 20);
      put(2, d[2], 20);
      put(3, d[3], 20);
      put(1, d[1], 20);
      put(0, d[0], 20);
      show(4'hF, 7'h7F, 10);
      n_cmp++;
      if (fv_cnt - f0 != 1 || count_bcd !== to_bcd(d) || count_bin !== 14'(to_bin(d)) || expired !== (to_bin(d) == 0)) begin
        n_bad++;
        $display("FAIL rand_frame%0d: got n %0d bcd %h bin %0d exp %b want 1/%h/%0d/%b", i,
                 fv_cnt - f0, count_bcd, count_bin, expired, to_bcd(d), to_bin(d), to_bin(d) == 0);
      end
    end
  endtask

  task automatic test_decode_err;
    int d [4];
    int f0 = fv_cnt, e0 = err_cnt;
    for (int p = 0; p < 4; p++) d[p] = $urandom_range(9);
    put(3, d[3], 20);
    put(2, d[2], 20);
    show(4'b0010, 7'h7F, 20);
    n_cmp++;
    if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL err_illegal: got %0d errors want 1", err_cnt - e0); end
    show(4'b0011, pats[d[1]], 20);
    n_cmp++;
    if (err_cnt - e0 != 2) begin n_bad++; $display("FAIL err_multi_an: got %0d errors want 2", err_cnt - e0); end
    show(4'hF, 7'h7F, 20);
    put(1, d[1], 20);
    put(0, d[0], 20);
    show(4'hF, 7'h7F, 10);
    n_cmp++;
    if (fv_cnt - f0 != 1 || count_bcd !== to_bcd(d) || err_cnt - e0 != 2) begin
      n_bad++;
      $display("FAIL err_mask_kept: got n %0d bcd %h errs %0d want 1/%h/2", fv_cnt - f0, count_bcd, err_cnt - e0, to_bcd(d));
    end
  endtask

  task automatic test_toggle;
    int d [4];
    int f0 = fv_cnt, e0 = err_cnt;
    for (int p = 0; p < 4; p++) d[p] = $urandom_range(9);
    for (int i = 0; i < 60; i++) begin
      put(0, d[0], 2);
      put(1, d[1], 2);
    end
    show(4'hF, 7'h7F, 10);
    put(3, d[3], 20);
    put(2, d[2], 20);
    put(1, d[1], 20);
    show(4'hF, 7'h7F, 10);
    n_cmp++;
    if (fv_cnt - f0 != 0 || err_cnt - e0 != 0) begin
      n_bad++;
      $display("FAIL toggle_noaccept: got %0d frames %0d errors want 0/0", fv_cnt - f0, err_cnt - e0);
    end
    put(0, d[0], 20);
    show(4'hF, 7'h7F, 10);
    n_cmp++;
    if (fv_cnt - f0 != 1 || count_bcd !== to_bcd(d)) begin
      n_bad++;
      $display("FAIL toggle_frame: got n %0d bcd %h want 1/%h", fv_cnt - f0, count_bcd, to_bcd(d));
    end
  endtask

  task automatic test_blank;
    int d [4];
    int f0;
    for (int p = 1; p < 4; p++) d[p] = $urandom_range(9);
    d[0] = 9;
    put(3, 0, 30);
    put(2, 1, 30);
    put(1, 9, 30);
    show(4'hF, 7'h7F, BT - 10);
    n_cmp++;
    if (blank !== 1'b0) begin n_bad++; $display("FAIL blank_early: got %b want 0", blank); end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (blank !== 1'b1 || flashing !== 1'b0) begin
      n_bad++;
      $display("FAIL blank_timeout: got blank %b flash %b want 1/0", blank, flashing);
    end
    f0 = fv_cnt;
    put(0, d[0], 30);
    n_cmp++;
    if (blank !== 1'b0 || flashing !== 1'b1 || fv_cnt != f0) begin
      n_bad++;
      $display("FAIL blank_resume: got blank %b flash %b frames %0d want 0/1/0", blank, flashing, fv_cnt - f0);
    end
    put(3, d[3], 30);
    put(2, d[2], 30);
    put(1, d[1], 30);
    n_cmp++;
    if (fv_cnt - f0 != 1 || count_bcd !== to_bcd(d)) begin
      n_bad++;
      $display("FAIL blank_discard: got n %0d bcd %h want 1/%h", fv_cnt - f0, count_bcd, to_bcd(d));
    end
    repeat (FH - 20 - 120) @(negedge clk);
    n_cmp++;
    if (flashing !== 1'b1) begin n_bad++; $display("FAIL flash_hold: got %b want 1", flashing); end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (flashing !== 1'b0) begin n_bad++; $display("FAIL flash_end: got %b want 0", flashing); end
  endtask

  task automatic test_reset_midframe;
    int d [4];
    int f0;
    for (int p = 0; p < 4; p++) d[p] = $urandom_range(9);
    put(3, $urandom_range(9), 20);
    put(2, $urandom_range(9), 20);
    put(1, $urandom_range(9), 20);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({count_bcd, count_bin, frame_valid, decode_err, blank, flashing, expired} !== '0) begin
      n_bad++;
      $display("FAIL midreset_out: outputs %h want 0", {count_bcd, count_bin, frame_valid, decode_err, blank, flashing, expired});
    end
    an = 4'hF;
    seg = 7'h7F;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    f0 = fv_cnt;
    put(0, d[0], 20);
    show(4'hF, 7'h7F, 10);
    n_cmp++;
    if (fv_cnt != f0 || count_bin !== 14'd0) begin
      n_bad++;
      $display("FAIL midreset_partial: got %0d frames bin %0d want 0/0", fv_cnt - f0, count_bin);
    end
    put(3, d[3], 20);
    put(2, d[2], 20);
    put(1, d[1], 20);
    show(4'hF, 7'h7F, 10);
    n_cmp++;
    if (fv_cnt - f0 != 1 || count_bcd !== to_bcd(d) || count_bin !== 14'(to_bin(d))) begin
      n_bad++;
      $display("FAIL midreset_frame: got n %0d bcd %h bin %0d want 1/%h/%0d", fv_cnt - f0, count_bcd, count_bin, to_bcd(d), to_bin(d));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    test_frame_0206;
    test_9999_0000;
    test_random_frames;
    test_decode_err;
    test_toggle;
    test_blank;
    test_reset_midframe;
    n_cmp++;
    if (both_cnt != 0) begin n_bad++; $display("FAIL fv_err_overlap: got %0d cycles want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/meter_reader.md
# meter_reader

Passive monitor on the parking meter's multiplexed seven-segment bus. It samples the active-low `an`/`seg` lines driven by the meter's display FSM, decodes each scanned digit back to BCD and assembles complete four-digit frames. It also converts each frame to binary and reports display blanking, flashing and expiry. It sits beside the meter in the top level, where board-level checks and the verification bench read the remaining time without touching the meter's internals.

## Interface
- `SETTLE`, 4: cycles `an`/`seg` must hold unchanged before a digit sample is accepted.
- `BLANK_TIMEOUT`, 1_000_000: cycles with no anode low before the display is declared blank.
- `FLASH_HOLD`, 300_000_000: cycles `flashing` stays set after the last blank-to-active transition.
- `clk` in 1: system clock, 100 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `an` in 4: meter anodes, active-low; `an[3]` = thousands … `an[0]` = ones.
- `seg` in 7: meter segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `count_bcd` out 16: last complete frame, 4 BCD digits, thousands in [15:12].
- `count_bin` out 14: binary value of `count_bcd`, 0–9999.
- `frame_valid` out 1: one-cycle pulse when `count_bcd`/`count_bin` update.
- `decode_err` out 1: one-cycle pulse on a rejected sample.
- `blank` out 1: no anode active for ≥ `BLANK_TIMEOUT` cycles.
- `flashing` out 1: a blank-to-active transition occurred within the last `FLASH_HOLD` cycles.
- `expired` out 1: last frame value equals 0.

## Operation
- `an`/`seg` pass through a 2-flop synchronizer. A stability counter restarts on any change of the 11-bit sampled vector and accepts the sample when it reaches `SETTLE`. Each stable interval yields at most one acceptance.
- Accepted sample with exactly one `an` bit low: decode `seg`. Legal patterns (g..a), 0–9 = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Legal: write the digit into that position's slot and set the position's bit in a 4-bit capture mask. A repeated position before the frame completes overwrites its slot.
  - Illegal pattern, or more than one anode low: pulse `decode_err`, discard the sample, leave the mask unchanged.
- Accepted sample with `an` = 1111: no capture, no error.
- Mask = 1111: copy slots to `count_bcd`, compute `count_bin` = 1000·d3 + 100·d2 + 10·d1 + d0, pulse `frame_valid`, update `expired`, clear the mask.
- Blank counter: increments while synchronized `an` = 1111, saturates at `BLANK_TIMEOUT`, and zeroes when any anode goes low. `blank` = 1 at saturation.
  - When an anode goes low while `blank` = 1: clear `blank` and the capture mask (a partial pre-blank frame is discarded), and load the flash counter with `FLASH_HOLD`.
- Flash counter decrements to 0. `flashing` = (flash counter ≠ 0).
- Top-level states: `IDLE` (no digit since reset), `SCAN` (capturing), `BLANK`.
  - `IDLE` → `SCAN` on the first legal capture.
  - `SCAN` → `BLANK` on blank-counter saturation.
  - `BLANK` → `SCAN` on any anode low.
  - `IDLE` → `BLANK` on saturation.

## Timing
- Reset values: all outputs 0, mask 0, state `IDLE`, all counters 0.
- Latency from an input change to sample acceptance: 2 sync cycles + `SETTLE` cycles.
- `frame_valid` asserts the cycle after the fourth position is captured. `count_bcd`, `count_bin` and `expired` are valid in that same cycle and hold until the next frame.
- `count_bin` is registered and updates in the same cycle as `count_bcd`; there is no multicycle path.
- `decode_err` and `frame_valid` never assert in the same cycle.
- Reset asserted mid-frame: the partial frame is lost. After release, a full fresh set of four positions is required.

## Structure
- Shared package `meter_pkg`:
  - the ten segment-pattern constants;
  - digit-position constants (`DIG_ONES`..`DIG_THOUS`);
  - the max count 9999;
  - the reader state enum.
- One sub-module, `seg7_decode`: combinational, 7-bit pattern → {valid, 4-bit digit}.
- All sequencing stays in `meter_reader`.

## Test plan
- Scan digits 0,2,0,6 (thousands → ones), 1000 cycles per digit → one `frame_valid`; `count_bcd` = 16'h0206, `count_bin` = 206, `expired` = 0.
- Scan 9,9,9,9, then 0,0,0,0 → two frames; `count_bin` = 9999, then 0; `expired` = 1 after the second.
- `an` = 0010 with `seg` = 1111111 → one `decode_err`, mask unchanged. `an` = 0011 with a legal pattern → one `decode_err`.
- `an` toggling every 2 cycles with `SETTLE` = 4 → no acceptance, no frame, no error.
- Scanning 0,1,9,9, hold `an` = 1111 for `BLANK_TIMEOUT` cycles, then resume → `blank` = 1 at timeout, clears on resume; `flashing` = 1 for `FLASH_HOLD` cycles; the partial frame is discarded.
- Three digits captured, pulse `reset_n` low → all outputs 0; the next frame requires all four positions.
